// File: rtl/enigma_keyer.sv
// enigma_keyer: types letters into an Enigma-style cipher core.
// Each accepted letter steps the rotors, holds the key for PRESS_CYCLES,
// captures the core's lamp output, then releases the key for RELEASE_CYCLES.
// The ciphered letter is offered through a one-deep valid/ready output buffer.
module enigma_keyer #(
    parameter int PRESS_CYCLES   = 1,   // 1..15
    parameter int RELEASE_CYCLES = 1    // 1..15
) (
    input  logic       clk,
    input  logic       restart,
    input  logic [4:0] in_letter,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       load,
    input  logic [4:0] start_l,
    input  logic [4:0] start_m,
    input  logic [4:0] start_r,
    output logic [4:0] key_bits,
    output logic [4:0] rot_l,
    output logic [4:0] rot_m,
    output logic [4:0] rot_r,
    input  logic [4:0] lamp,
    output logic [4:0] out_letter,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err
);

    localparam logic [4:0] NO_KEY     = 5'd31;
    localparam logic [4:0] LAST_POS   = 5'd25;
    localparam logic [3:0] PRESS_CNT  = 4'(PRESS_CYCLES);
    localparam logic [3:0] RELEASE_CNT = 4'(RELEASE_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       accept;
    logic       letter_ok;

    // Out-of-range start positions fall back to the zero position.
    function automatic logic [4:0] clamp_pos(input logic [4:0] pos);
        return (pos > LAST_POS) ? 5'd0 : pos;
    endfunction

    // Advance one rotor position modulo 26.
    function automatic logic [4:0] inc_pos(input logic [4:0] pos);
        return (pos >= LAST_POS) ? 5'd0 : pos + 5'd1;
    endfunction

    // Letters are accepted only in IDLE with an empty output buffer; load
    // blocks acceptance so a rotor load always wins over a new letter.
    // Held low during restart, and rises as soon as restart is released.
    assign in_ready  = restart && (state == IDLE) && !out_valid && !load;
    assign accept    = in_valid && in_ready;
    assign letter_ok = (in_letter <= LAST_POS);

    // Keystroke FSM with rotors, key bus, output buffer and error pulse.
    // key_bits doubles as the latched letter, and rotors and key_bits are
    // written on the same edge so the core never sees a mixed state.
    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            key_bits   <= NO_KEY;
            rot_l      <= 5'd0;
            rot_m      <= 5'd0;
            rot_r      <= 5'd0;
            out_letter <= 5'd0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;

            // Consumer drains the output buffer.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    key_bits <= NO_KEY;
                    if (load) begin
                        rot_l <= clamp_pos(start_l);
                        rot_m <= clamp_pos(start_m);
                        rot_r <= clamp_pos(start_r);
                    end else if (accept) begin
                        if (letter_ok) begin
                            key_bits <= in_letter;
                            cnt      <= PRESS_CNT;
                            state    <= PRESS;
                            // Odometer stepping: middle follows a right wrap,
                            // left follows a middle wrap in that same step.
                            rot_r    <= inc_pos(rot_r);
                            if (rot_r == LAST_POS) begin
                                rot_m <= inc_pos(rot_m);
                                if (rot_m == LAST_POS) begin
                                    rot_l <= inc_pos(rot_l);
                                end
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                PRESS: begin
                    if (cnt == 4'd1) begin
                        // Capture the core's answer while the key is still down.
                        out_letter <= lamp;
                        out_valid  <= 1'b1;
                        key_bits   <= NO_KEY;
                        cnt        <= RELEASE_CNT;
                        state      <= RELEASE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                RELEASE: begin
                    key_bits <= NO_KEY;
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                default: begin
                    key_bits <= NO_KEY;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enigma_keyer.sv
// Bench for enigma_keyer: one instance with 1/1 press/release timing and
// one with 4/1 timing. The cipher core is modelled as (key + rot_r) mod 26.
module tb_enigma_keyer;

    logic       clk = 1'b0;
    int         checks = 0;
    int         failures = 0;

    // Instance A: PRESS_CYCLES=1, RELEASE_CYCLES=1
    logic       restart;
    logic [4:0] in_letter;
    logic       in_valid;
    logic       in_ready;
    logic       load;
    logic [4:0] start_l, start_m, start_r;
    logic [4:0] key_bits;
    logic [4:0] rot_l, rot_m, rot_r;
    logic [4:0] lamp;
    logic [4:0] out_letter;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    // Instance B: PRESS_CYCLES=4, RELEASE_CYCLES=1
    logic       restart4;
    logic [4:0] in_letter4;
    logic       in_valid4;
    logic       in_ready4;
    logic       load4;
    logic [4:0] key_bits4;
    logic [4:0] rot_l4, rot_m4, rot_r4;
    logic [4:0] lamp4;
    logic [4:0] out_letter4;
    logic       out_valid4;
    logic       out_ready4;
    logic       err4;

    // Rotor models and expected-output scoreboards
    int m_l = 0, m_m = 0, m_r = 0;
    int m4_l = 0, m4_m = 0, m4_r = 0;
    int exp_q[$];
    int exp4_q[$];

    always #5 clk = ~clk;

    assign lamp  = (key_bits  == 5'd31) ? 5'd0 : 5'(({1'b0, key_bits}  + {1'b0, rot_r})  % 6'd26);
    assign lamp4 = (key_bits4 == 5'd31) ? 5'd0 : 5'(({1'b0, key_bits4} + {1'b0, rot_r4}) % 6'd26);

    enigma_keyer #(.PRESS_CYCLES(1), .RELEASE_CYCLES(1)) dut (
        .clk(clk), .restart(restart), .in_letter(in_letter), .in_valid(in_valid),
        .in_ready(in_ready), .load(load), .start_l(start_l), .start_m(start_m),
        .start_r(start_r), .key_bits(key_bits), .rot_l(rot_l), .rot_m(rot_m),
        .rot_r(rot_r), .lamp(lamp), .out_letter(out_letter), .out_valid(out_valid),
        .out_ready(out_ready), .err(err)
    );

    enigma_keyer #(.PRESS_CYCLES(4), .RELEASE_CYCLES(1)) dut4 (
        .clk(clk), .restart(restart4), .in_letter(in_letter4), .in_valid(in_valid4),
        .in_ready(in_ready4), .load(load4), .start_l(start_l), .start_m(start_m),
        .start_r(start_r), .key_bits(key_bits4), .rot_l(rot_l4), .rot_m(rot_m4),
        .rot_r(rot_r4), .lamp(lamp4), .out_letter(out_letter4), .out_valid(out_valid4),
        .out_ready(out_ready4), .err(err4)
    );

    task automatic model_step();
        m_r = (m_r + 1) % 26;
        if (m_r == 0) begin
            m_m = (m_m + 1) % 26;
            if (m_m == 0) m_l = (m_l + 1) % 26;
        end
    endtask

    task automatic wait_ready(output bit timed_out);
        for (int i = 0; i < 40 && in_ready !== 1'b1; i++) @(negedge clk);
        timed_out = (in_ready !== 1'b1);
    endtask

    task automatic wait_valid(output bit timed_out);
        for (int i = 0; i < 40 && out_valid !== 1'b1; i++) @(negedge clk);
        timed_out = (out_valid !== 1'b1);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (key_bits !== 5'd31) begin failures++; $display("FAIL reset_key: got %0d expected 31", key_bits); end
        checks++;
        if ({rot_l, rot_m, rot_r} !== 15'd0) begin failures++; $display("FAIL reset_rot: got %0d,%0d,%0d expected 0,0,0", rot_l, rot_m, rot_r); end
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b0 || out_letter !== 5'd0) begin
            failures++; $display("FAIL reset_out: got valid=%0b err=%0b letter=%0d expected 0,0,0", out_valid, err, out_letter);
        end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
        checks++;
        if (key_bits4 !== 5'd31) begin failures++; $display("FAIL reset_key4: got %0d expected 31", key_bits4); end
        @(negedge clk);
        restart  = 1'b1;
        restart4 = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %0b expected 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_single();
        bit to;
        int e;
        out_ready = 1'b0;
        in_letter = 5'd10;
        in_valid  = 1'b1;
        model_step();
        exp_q.push_back((10 + m_r) % 26);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (key_bits !== 5'd10 || rot_r !== m_r[4:0]) begin
            failures++; $display("FAIL single_press: got key=%0d rot_r=%0d expected 10,%0d", key_bits, rot_r, m_r);
        end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %0b expected 0", out_valid); end
        wait_valid(to);
        checks++;
        if (to) begin failures++; $display("FAIL single_valid_timeout: got 0 expected 1"); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++;
        if (key_bits !== 5'd31 || out_letter !== e[4:0]) begin
            failures++; $display("FAIL single_out: got key=%0d letter=%0d expected 31,%0d", key_bits, out_letter, e);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_letter !== e[4:0] || key_bits !== 5'd31) begin
                failures++; $display("FAIL single_hold: got valid=%0b letter=%0d key=%0d expected 1,%0d,31", out_valid, out_letter, key_bits, e);
            end
        end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL single_stall_ready: got %0b expected 0", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL single_drain: got valid=%0b ready=%0b expected 0,1", out_valid, in_ready);
        end
    endtask

    task automatic test_cascade();
        bit to;
        int e;
        load = 1'b1;
        start_l = 5'd0; start_m = 5'd25; start_r = 5'd25;
        @(negedge clk);
        load = 1'b0;
        m_l = 0; m_m = 25; m_r = 25;
        checks++;
        if ({rot_l, rot_m, rot_r} !== {5'd0, 5'd25, 5'd25}) begin
            failures++; $display("FAIL cascade_load: got %0d,%0d,%0d expected 0,25,25", rot_l, rot_m, rot_r);
        end
        in_letter = 5'd4;
        in_valid  = 1'b1;
        model_step();
        exp_q.push_back((4 + m_r) % 26);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({rot_l, rot_m, rot_r} !== {5'd1, 5'd0, 5'd0} || key_bits !== 5'd4) begin
            failures++; $display("FAIL cascade_step: got %0d,%0d,%0d key=%0d expected 1,0,0 key=4", rot_l, rot_m, rot_r, key_bits);
        end
        wait_valid(to);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++;
        if (to || out_letter !== e[4:0]) begin
            failures++; $display("FAIL cascade_out: got %0d expected %0d", out_letter, e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_invalid();
        bit to;
        wait_ready(to);
        checks++;
        if (to) begin failures++; $display("FAIL invalid_ready_timeout: got 0 expected 1"); end
        in_letter = 5'd28;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL invalid_err: got %0b expected 1", err); end
        checks++;
        if ({rot_l, rot_m, rot_r} !== {m_l[4:0], m_m[4:0], m_r[4:0]} || key_bits !== 5'd31) begin
            failures++; $display("FAIL invalid_state: got %0d,%0d,%0d key=%0d expected %0d,%0d,%0d key=31", rot_l, rot_m, rot_r, key_bits, m_l, m_m, m_r);
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL invalid_in_ready: got %0b expected 1", in_ready); end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || key_bits !== 5'd31) begin
            failures++; $display("FAIL invalid_pulse_end: got err=%0b key=%0d expected 0,31", err, key_bits);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int e;
        out_ready = 1'b0;
        wait_ready(to);
        in_letter = 5'd25;
        in_valid  = 1'b1;
        model_step();
        exp_q.push_back((25 + m_r) % 26);
        @(negedge clk);
        checks++;
        if (key_bits !== 5'd25) begin failures++; $display("FAIL bp_first_key: got %0d expected 25", key_bits); end
        in_letter = 5'd20;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || key_bits === 5'd20 || rot_r !== m_r[4:0]) begin
                failures++; $display("FAIL bp_blocked: got ready=%0b key=%0d rot_r=%0d expected 0,!20,%0d", in_ready, key_bits, rot_r, m_r);
            end
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++;
        if (out_valid !== 1'b1 || out_letter !== e[4:0]) begin
            failures++; $display("FAIL bp_first_out: got valid=%0b letter=%0d expected 1,%0d", out_valid, out_letter, e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || key_bits !== 5'd31 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release: got valid=%0b key=%0d ready=%0b expected 0,31,1", out_valid, key_bits, in_ready);
        end
        model_step();
        exp_q.push_back((20 + m_r) % 26);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (key_bits !== 5'd20 || rot_r !== m_r[4:0]) begin
            failures++; $display("FAIL bp_second_key: got key=%0d rot_r=%0d expected 20,%0d", key_bits, rot_r, m_r);
        end
        wait_valid(to);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++;
        if (to || out_letter !== e[4:0]) begin
            failures++; $display("FAIL bp_second_out: got %0d expected %0d", out_letter, e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_load_busy();
        bit to;
        int e;
        wait_ready(to);
        in_letter = 5'd5;
        in_valid  = 1'b1;
        model_step();
        exp_q.push_back((5 + m_r) % 26);
        @(negedge clk);
        in_valid = 1'b0;
        load = 1'b1;
        start_l = 5'd3; start_m = 5'd3; start_r = 5'd3;
        checks++;
        if (key_bits !== 5'd5) begin failures++; $display("FAIL busy_key: got %0d expected 5", key_bits); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({rot_l, rot_m, rot_r} !== {m_l[4:0], m_m[4:0], m_r[4:0]}) begin
                failures++; $display("FAIL busy_rot: got %0d,%0d,%0d expected %0d,%0d,%0d", rot_l, rot_m, rot_r, m_l, m_m, m_r);
            end
        end
        load = 1'b0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++;
        if (out_valid !== 1'b1 || out_letter !== e[4:0]) begin
            failures++; $display("FAIL busy_out: got valid=%0b letter=%0d expected 1,%0d", out_valid, out_letter, e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_load_priority();
        bit to;
        wait_ready(to);
        load = 1'b1;
        start_l = 5'd30; start_m = 5'd2; start_r = 5'd7;
        in_letter = 5'd9;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL prio_in_ready: got %0b expected 0", in_ready); end
        @(negedge clk);
        load = 1'b0;
        in_valid = 1'b0;
        m_l = 0; m_m = 2; m_r = 7;
        checks++;
        if ({rot_l, rot_m, rot_r} !== {5'd0, 5'd2, 5'd7} || key_bits !== 5'd31) begin
            failures++; $display("FAIL prio_load: got %0d,%0d,%0d key=%0d expected 0,2,7 key=31", rot_l, rot_m, rot_r, key_bits);
        end
    endtask

    task automatic test_reset_mid_press();
        bit seen;
        in_letter4 = 5'd7;
        in_valid4  = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        checks++;
        if (key_bits4 !== 5'd7 || rot_r4 !== 5'd1) begin
            failures++; $display("FAIL mid_press_start: got key=%0d rot_r=%0d expected 7,1", key_bits4, rot_r4);
        end
        @(negedge clk);
        restart4 = 1'b0;
        #1;
        checks++;
        if (key_bits4 !== 5'd31 || {rot_l4, rot_m4, rot_r4} !== 15'd0 || in_ready4 !== 1'b0) begin
            failures++; $display("FAIL mid_press_abort: got key=%0d rot=%0d,%0d,%0d ready=%0b expected 31,0,0,0,0", key_bits4, rot_l4, rot_m4, rot_r4, in_ready4);
        end
        @(negedge clk);
        @(negedge clk);
        restart4 = 1'b1;
        m4_l = 0; m4_m = 0; m4_r = 0;
        exp4_q.delete();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid4 !== 1'b0 || key_bits4 !== 5'd31) seen = 1'b1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL mid_press_no_output: got out_valid or key activity expected none"); end
    endtask

    task automatic test_press_timing();
        int e;
        out_ready4 = 1'b0;
        in_letter4 = 5'd3;
        in_valid4  = 1'b1;
        m4_r = (m4_r + 1) % 26;
        exp4_q.push_back((3 + m4_r) % 26);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid4 = 1'b0;
            checks++;
            if (key_bits4 !== 5'd3 || out_valid4 !== 1'b0) begin
                failures++; $display("FAIL p4_press_cycle%0d: got key=%0d valid=%0b expected 3,0", k, key_bits4, out_valid4);
            end
        end
        @(negedge clk);
        e = (exp4_q.size() > 0) ? exp4_q.pop_front() : -1;
        checks++;
        if (key_bits4 !== 5'd31 || out_valid4 !== 1'b1 || out_letter4 !== e[4:0]) begin
            failures++; $display("FAIL p4_out: got key=%0d valid=%0b letter=%0d expected 31,1,%0d", key_bits4, out_valid4, out_letter4, e);
        end
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        checks++;
        if (out_valid4 !== 1'b0) begin failures++; $display("FAIL p4_drain: got %0b expected 0", out_valid4); end
    endtask

    initial begin
        restart = 1'b0; restart4 = 1'b0;
        in_letter = 5'd0; in_valid = 1'b0; load = 1'b0; out_ready = 1'b0;
        in_letter4 = 5'd0; in_valid4 = 1'b0; load4 = 1'b0; out_ready4 = 1'b0;
        start_l = 5'd0; start_m = 5'd0; start_r = 5'd0;
        test_reset();
        test_single();
        test_cascade();
        test_invalid();
        test_backpressure();
        test_load_busy();
        test_load_priority();
        test_reset_mid_press();
        test_press_timing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
